restoring_divider: RTL

Multi-cycle unsigned integer divider for the ALU datapath, the inverse operation to the shift-add multiplier. A one-cycle `start` pulse captures dividend `A` and divisor `B`. The block then runs one restoring shift-subtract iteration per clock and presents `quotient` and `remainder` with a level `finished` flag. It sits beside the multiplier behind the ALU result mux and uses the same start/finished handshake.

---
 rtl/alu_pkg.sv | 17 +
 rtl/adder.sv | 13 +
 rtl/restoring_divider_div_step.sv | 31 +++
 rtl/restoring_divider.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width and divider state encoding.
// Used by restoring_divider and the neighbouring shift-add multiplier.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_RUN  = 2'd1;
  localparam logic [1:0] DIV_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = DIV_IDLE,
    ST_RUN  = DIV_RUN,
    ST_DONE = DIV_DONE
  } div_state_e;

endpackage

// File: rtl/adder.sv
// Plain W-bit adder with carry-in; carry-out is discarded by design.
module Adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum
);

  assign sum = a + b + {{(W-1){1'b0}}, cin};

endmodule

// File: rtl/restoring_divider_div_step.sv
// One combinational restoring shift-subtract iteration of the divider.
// The subtraction is formed as R' + ~{0,D} + 1 through the shared Adder.
module div_step #(
  parameter int n = 8
) (
  input  logic [n-1:0] r_i,
  input  logic         q_msb_i,
  input  logic [n-1:0] d_i,
  output logic [n-1:0] r_o,
  output logic         q_bit_o
);

  logic [n:0] r_shift;
  logic [n:0] diff;

  assign r_shift = {r_i, q_msb_i};

  Adder #(.W(n + 1)) u_sub (
    .a   (r_shift),
    .b   (~{1'b0, d_i}),
    .cin (1'b1),
    .sum (diff)
  );

  // A negative difference restores R'; R'[n] is then provably zero since R' < D.
  always_comb begin
    q_bit_o = ~diff[n];
    r_o     = diff[n] ? r_shift[n-1:0] : diff[n-1:0];
  end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider with start/finished handshake.
// Optional feature macro: DIVIDER_DBZ_FLAG_EN (early-out divide-by-zero flag).
module restoring_divider
  import alu_pkg::*;
#(
  parameter int n = ALU_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic [n-1:0] quotient,
  output logic [n-1:0] remainder,
  output logic         finished,
`ifdef DIVIDER_DBZ_FLAG_EN
  output logic         div_by_zero,
`endif
  output logic [1:0]   dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE/DONE;
  // finished is a level that holds results until the next accepted start.
  localparam int CW = $clog2(n);

  div_state_e    state_q, state_d;
  logic [n-1:0]  q_q, q_d;
  // The top remainder bit is always zero between iterations, so R keeps n bits.
  logic [n-1:0]  r_q, r_d;
  logic [n-1:0]  d_q, d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fin_q, fin_d;
  logic          dbz_hold;
  logic [n-1:0]  step_r;
  logic          step_qbit;

`ifdef DIVIDER_DBZ_FLAG_EN
  logic dbz_q, dbz_d;
  assign dbz_hold = dbz_q;
`else
  assign dbz_hold = 1'b0;
`endif

  div_step #(.n(n)) u_step (
    .r_i     (r_q),
    .q_msb_i (q_q[n-1]),
    .d_i     (d_q),
    .r_o     (step_r),
    .q_bit_o (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    fin_d   = fin_q;
`ifdef DIVIDER_DBZ_FLAG_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          q_d     = A;
          r_d     = '0;
          d_d     = B;
          cnt_d   = '0;
          fin_d   = 1'b0;
`ifdef DIVIDER_DBZ_FLAG_EN
          dbz_d   = (B == '0);
`endif
        end
      end
      ST_RUN: begin
        if (dbz_hold) begin
          // Zero divisor: Q still holds the dividend, so publish the fixed result.
          q_d     = '1;
          r_d     = q_q;
          state_d = ST_DONE;
          fin_d   = 1'b1;
        end else begin
          q_d   = {q_q[n-2:0], step_qbit};
          r_d   = step_r;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(n - 1)) begin
            state_d = ST_DONE;
            fin_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      fin_q   <= 1'b0;
`ifdef DIVIDER_DBZ_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      fin_q   <= fin_d;
`ifdef DIVIDER_DBZ_FLAG_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign quotient  = q_q;
  assign remainder = r_q;
  assign finished  = fin_q;
  assign dbg_state = state_q;
`ifdef DIVIDER_DBZ_FLAG_EN
  assign div_by_zero = dbz_q;
`endif

endmodule
